// File: rtl/ramcon_arbiter.sv
// ramcon_arbiter: round-robin arbiter letting two Wishbone B4 pipelined masters share the ramcon SRAM port
module ramcon_arbiter #(
    parameter int ADR_W   = 19,
    parameter int DAT_W   = 16,
    parameter int SEL_W   = 2,
    parameter int MAX_OUT = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic             m0_ack_o,
    output logic             m0_stall_o,
    output logic [DAT_W-1:0] m0_dat_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic             m1_ack_o,
    output logic             m1_stall_o,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic             s_ack_i,
    input  logic             s_stall_i,
    input  logic [DAT_W-1:0] s_dat_i
);
    localparam int CW = $clog2(MAX_OUT + 1);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;
    state_t state, state_nx;
    logic last;
    logic [CW-1:0] outstanding, out_nx;
    logic own, own1, cyc, full, accept, retire;

    // state, last-granted master and in-flight transfer counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            last        <= 1'b1;
            outstanding <= '0;
        end else begin
            state       <= state_nx;
            outstanding <= out_nx;
            if (state_nx == OWN0 || state_nx == OWN1) last <= state_nx == OWN1;
        end
    end

    // owner mux towards ramcon and stall/ack steering back to the masters
    always_comb begin
        own1       = state == OWN1;
        own        = state == OWN0 || own1;
        cyc        = own1 ? m1_cyc_i : m0_cyc_i;
        full       = outstanding == CW'(MAX_OUT);
        s_cyc_o    = (own && cyc) || state == DRAIN;
        s_stb_o    = own && cyc && (own1 ? m1_stb_i : m0_stb_i) && !full;
        s_we_o     = own1 ? m1_we_i : m0_we_i;
        s_sel_o    = own1 ? m1_sel_i : m0_sel_i;
        s_adr_o    = own1 ? m1_adr_i : m0_adr_i;
        s_dat_o    = own1 ? m1_dat_i : m0_dat_i;
        m0_stall_o = state != OWN0 || s_stall_i || full;
        m1_stall_o = !own1 || s_stall_i || full;
        m0_ack_o   = state == OWN0 && m0_cyc_i && s_ack_i;
        m1_ack_o   = own1 && m1_cyc_i && s_ack_i;
        m0_dat_o   = s_dat_i;
        m1_dat_o   = s_dat_i;
    end

    // in-flight bookkeeping and grant/release decisions; a stray ack at zero is dropped
    always_comb begin
        accept   = s_stb_o && !s_stall_i;
        retire   = s_ack_i && outstanding != '0;
        out_nx   = outstanding + CW'(accept) - CW'(retire);
        state_nx = state;
        case (state)
            IDLE:       state_nx = (m0_cyc_i && (!m1_cyc_i || last)) ? OWN0 : (m1_cyc_i ? OWN1 : IDLE);
            OWN0, OWN1: if (!cyc) state_nx = out_nx == '0 ? IDLE : DRAIN;
            DRAIN:      if (out_nx == '0) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ramcon_arbiter.sv
// tb_ramcon_arbiter: scoreboard bench with master/ramcon bus models and a transaction-level memory reference
module tb_ramcon_arbiter;
    localparam int ADR_W = 19;
    localparam int DAT_W = 16;
    localparam int SEL_W = 2;
    localparam int MAX_OUT = 3;

    typedef struct packed {
        logic             rd;
        logic [DAT_W-1:0] dat;
    } exp_t;
    typedef struct packed {
        int               due;
        logic             src;
        logic [DAT_W-1:0] dat;
    } pend_t;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic [1:0] m_cyc = '0, m_stb = '0, m_we = '0;
    logic [SEL_W-1:0] m_sel [2];
    logic [ADR_W-1:0] m_adr [2];
    logic [DAT_W-1:0] m_wdat [2];
    logic m0_ack, m1_ack, m0_stall, m1_stall;
    logic [DAT_W-1:0] m0_rdat, m1_rdat;
    logic s_cyc, s_stb, s_we;
    logic [SEL_W-1:0] s_sel;
    logic [ADR_W-1:0] s_adr;
    logic [DAT_W-1:0] s_wdat;
    logic [DAT_W-1:0] s_rdat = '0;
    logic s_ack = 0, s_stall = 0;

    int checks = 0, errors = 0;
    int cyc_n = 0, inflight = 0, max_inflight = 0;
    int stall_pct = 0, dly_min = 1, dly_max = 1;
    bit gapless = 1, force_rd = 0;
    int ack_cnt [2] = '{0, 0};
    int grant_log[$];
    exp_t exp_q[2][$];
    pend_t pend[$];
    logic [DAT_W-1:0] ref_mem [512];
    logic [DAT_W-1:0] slv_mem [512];

    ramcon_arbiter dut (
        .clk_i(clk), .reset_i(rst),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_ack_o(m0_ack), .m0_stall_o(m0_stall), .m0_dat_o(m0_rdat),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_ack_o(m1_ack), .m1_stall_o(m1_stall), .m1_dat_o(m1_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_wdat),
        .s_ack_i(s_ack), .s_stall_i(s_stall), .s_dat_i(s_rdat)
    );

    function automatic logic stall_of(input int m);
        return m != 0 ? m1_stall : m0_stall;
    endfunction

    function automatic logic ack_of(input int m);
        return m != 0 ? m1_ack : m0_ack;
    endfunction

    function automatic logic [DAT_W-1:0] rdat_of(input int m);
        return m != 0 ? m1_rdat : m0_rdat;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // each master owns its own half of the 512-word window (address bit 8 = master id)
    function automatic void new_xfer(input int m);
        m_stb[m]  = 1'b1;
        m_we[m]   = force_rd ? 1'b0 : 1'($urandom);
        m_sel[m]  = SEL_W'($urandom_range(3, 1));
        m_adr[m]  = {10'b0, 1'(m), 8'($urandom)};
        m_wdat[m] = DAT_W'($urandom);
    endfunction

    // reference memory follows accepted transfers in master order; reads expect its current word
    function automatic void accept_xfer(input int m);
        exp_t e;
        int idx = int'(m_adr[m][8:0]);
        if (m_we[m])
            for (int b = 0; b < SEL_W; b++)
                if (m_sel[m][b]) ref_mem[idx][b*8 +: 8] = m_wdat[m][b*8 +: 8];
        e.rd  = !m_we[m];
        e.dat = ref_mem[idx];
        exp_q[m].push_back(e);
    endfunction

    task automatic wait_acks(input int m, input int target);
        int n = 0;
        while (ack_cnt[m] < target) begin
            @(negedge clk);
            if (++n > 400) begin
                chk("ack_timeout", ack_cnt[m], target);
                break;
            end
        end
    endtask

    task automatic master_cycle(input int m, input int n, input bit abort);
        int acc = 0, waited = 0, target = ack_cnt[m];
        bit own = 0, went;
        @(negedge clk);
        m_cyc[m] = 1'b1;
        new_xfer(m);
        while (acc < n) begin
            #2;
            if (own) chk("owner_stall", stall_of(m), s_stall || inflight >= MAX_OUT);
            went = m_stb[m] && !stall_of(m);
            if (went) begin
                if (!own) grant_log.push_back(m);
                own = 1;
                accept_xfer(m);
                acc++;
            end
            @(negedge clk);
            if (++waited > 400) begin
                chk("grant_timeout", acc, n);
                break;
            end
            if (went && !(acc < n && (gapless || $urandom_range(3) != 0))) m_stb[m] = 1'b0;
            else if (acc < n && (went || !m_stb[m])) new_xfer(m);
        end
        m_stb[m] = 1'b0;
        if (abort) begin
            m_cyc[m] = 1'b0;
            exp_q[m].delete();
        end else begin
            wait_acks(m, target + acc);
            m_cyc[m] = 1'b0;
        end
    endtask

    // ramcon model: random stall, in-order acks after a per-transfer delay
    initial begin
        pend_t p;
        int idx;
        bit mixed;
        forever begin
            @(negedge clk);
            cyc_n++;
            s_stall = $urandom_range(99) < 32'(stall_pct);
            s_ack = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc_n) begin
                s_ack  = 1'b1;
                s_rdat = pend[0].dat;
                void'(pend.pop_front());
            end
            #1;
            inflight = pend.size() + int'(s_ack);
            if (inflight > max_inflight) max_inflight = inflight;
            if (s_cyc && s_stb && !s_stall) begin
                chk("inflight_limit", 32'(inflight < MAX_OUT), 1);
                mixed = 0;
                foreach (pend[i]) if (pend[i].src != s_adr[8]) mixed = 1;
                chk("owner_switch_pending", 32'(mixed), 0);
                idx = int'(s_adr[8:0]);
                if (s_we)
                    for (int b = 0; b < SEL_W; b++)
                        if (s_sel[b]) slv_mem[idx][b*8 +: 8] = s_wdat[b*8 +: 8];
                p.src = s_adr[8];
                p.dat = slv_mem[idx];
                p.due = cyc_n + int'($urandom_range(dly_max, dly_min));
                pend.push_back(p);
            end
        end
    end

    // ack monitor: every forwarded ack must match the head of that master's expectations
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            for (int m = 0; m < 2; m++) begin
                if (ack_of(m)) begin
                    chk("ack_expected", 32'(exp_q[m].size() > 0), 1);
                    if (exp_q[m].size() > 0) begin
                        e = exp_q[m].pop_front();
                        if (e.rd) chk("read_data", rdat_of(m), e.dat);
                    end
                    ack_cnt[m]++;
                end
            end
            chk("single_owner", m0_stall | m1_stall, 1);
        end
    end

    initial begin
        int b0, b1, n;
        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = DAT_W'($urandom);
            slv_mem[i] = ref_mem[i];
        end
        for (int m = 0; m < 2; m++) begin
            m_sel[m] = '0;
            m_adr[m] = '0;
            m_wdat[m] = '0;
        end
        repeat (2) @(negedge clk);
        #2;
        chk("rst_m0_stall", m0_stall, 1);
        chk("rst_m1_stall", m1_stall, 1);
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_ack", m1_ack, 0);
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_s_stb", s_stb, 0);
        rst = 0;

        b0 = ack_cnt[0];
        @(negedge clk);
        m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 1; m_sel[0] = '1;
        m_adr[0] = 19'h00010; m_wdat[0] = 16'h1234;
        #2;
        chk("grant_latency_stall", m0_stall, 1);
        chk("grant_latency_cyc", s_cyc, 0);
        @(negedge clk);
        #2;
        chk("wr_adr", s_adr, 19'h00010);
        chk("wr_dat", s_wdat, 16'h1234);
        chk("wr_we", s_we, 1);
        chk("wr_stb", s_stb, 1);
        chk("wr_m0_stall", m0_stall, 0);
        accept_xfer(0);
        @(negedge clk);
        m_stb[0] = 0;
        wait_acks(0, b0 + 1);
        m_cyc[0] = 0;

        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        grant_log.delete();
        fork
            begin master_cycle(0, 2, 0); master_cycle(0, 2, 0); end
            begin master_cycle(1, 2, 0); master_cycle(1, 2, 0); end
        join
        chk("rr_count", grant_log.size(), 4);
        foreach (grant_log[i]) chk("rr_order", grant_log[i], i % 2);

        dly_min = 4; dly_max = 4; force_rd = 1;
        b0 = ack_cnt[0]; b1 = ack_cnt[1];
        @(negedge clk);
        max_inflight = 0;
        master_cycle(1, 5, 0);
        chk("burst_max_inflight", max_inflight, MAX_OUT);
        chk("burst_m1_acks", ack_cnt[1] - b1, 5);
        chk("burst_m0_acks", ack_cnt[0], b0);
        force_rd = 0;

        b0 = ack_cnt[0]; b1 = ack_cnt[1];
        fork
            master_cycle(0, 2, 1);
            begin repeat (2) @(negedge clk); master_cycle(1, 3, 0); end
        join
        chk("drain_m0_acks", ack_cnt[0], b0);
        chk("drain_m1_acks", ack_cnt[1] - b1, 3);

        dly_min = 2; dly_max = 2;
        @(negedge clk);
        max_inflight = 0;
        master_cycle(0, 8, 0);
        chk("steady_inflight", max_inflight, 2);

        dly_min = 8; dly_max = 8;
        b1 = ack_cnt[1];
        master_cycle(1, 2, 1);
        rst = 1;
        #2;
        chk("rst_own1_ack", m1_ack, 0);
        @(negedge clk);
        #2;
        chk("rst_own1_m1_stall", m1_stall, 1);
        chk("rst_own1_m0_stall", m0_stall, 1);
        chk("rst_own1_s_cyc", s_cyc, 0);
        @(negedge clk);
        rst = 0;
        n = 0;
        while (pend.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stale_drained", pend.size(), 0);
        chk("rst_no_fwd_ack", ack_cnt[1], b1);
        dly_min = 1; dly_max = 1;
        master_cycle(0, 3, 0);

        stall_pct = 25; dly_min = 1; dly_max = 5; gapless = 0;
        fork
            for (int k = 0; k < 12; k++) begin
                master_cycle(0, $urandom_range(6, 1), 0);
                repeat ($urandom_range(3)) @(negedge clk);
            end
            for (int k = 0; k < 12; k++) begin
                master_cycle(1, $urandom_range(6, 1), 0);
                repeat ($urandom_range(3)) @(negedge clk);
            end
        join
        repeat (4) @(negedge clk);
        chk("final_m0_queue", exp_q[0].size(), 0);
        chk("final_m1_queue", exp_q[1].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
